cbus_arbiter: RTL and testbench

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/cbus_arbiter.sv | 121 ++++++++++++
 tb/tb_cbus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cbus port among NUM_INPUTS requesters, holding each grant until the last beat.
// Latency: 1-cycle grant after valid; backpressure: oresp.ready/last passed straight to the granted requester only.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int  NUM_INPUTS = 2,
    localparam int IDX_W      = $clog2(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);
    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] rr_q;
    logic [IDX_W-1:0] gnt_q;
    logic [7:0]       beat_q;
    logic             busy_q;

    logic [IDX_W-1:0] pick_d;
    logic [IDX_W-1:0] rr_inc_d;
    logic             any_vld_d;
    logic             sel_vld_d;

    // Scan from the highest offset down so the lowest offset from rr_q wins.
    always_comb begin
        pick_d    = rr_q;
        any_vld_d = 1'b0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (ireqs[(int'(rr_q) + k) % NUM_INPUTS].valid) begin
                any_vld_d = 1'b1;
                pick_d    = IDX_W'((int'(rr_q) + k) % NUM_INPUTS);
            end
        end
    end

    assign rr_inc_d = (sel_q == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel_q + IDX_W'(1);

    always_comb begin
        oreq      = '0;
        sel_vld_d = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
            if (sel_q == IDX_W'(i)) begin
                sel_vld_d = ireqs[i].valid;
                if (state_q == BUSY) begin
                    oreq      = ireqs[i];
                    iresps[i] = oresp;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            gnt_q   <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_vld_d) begin
                        state_q <= BUSY;
                        sel_q   <= pick_d;
                        gnt_q   <= pick_d;
                        busy_q  <= 1'b1;
                        beat_q  <= '0;
                    end
                end
                BUSY: begin
                    if (oresp.ready && oresp.last) begin
                        state_q <= IDLE;
                        rr_q    <= rr_inc_d;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        beat_q  <= '0;
                    end else if (beat_q == 8'd0 && !sel_vld_d) begin
                        // Requester withdrew before any data moved: release without advancing rr.
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (oresp.ready && beat_q != 8'hFF) begin
                        beat_q <= beat_q + 8'd1;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign grant_idx = gnt_q;
endmodule

// File: tb/tb_cbus_arbiter.sv
// Bench for cbus_arbiter: directed cycle table on a 2-input instance, fairness and randomized model check on a 4-input instance.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst2, rst4;
    cbus_req_t  req2 [2];
    cbus_resp_t resp2 [2];
    cbus_req_t  oreq2;
    cbus_resp_t oresp2;
    logic       busy2;
    logic [0:0] gnt2;

    cbus_req_t  req4 [4];
    cbus_resp_t resp4 [4];
    cbus_req_t  oreq4;
    cbus_resp_t oresp4;
    logic       busy4;
    logic [1:0] gnt4;

    cbus_arbiter #(.NUM_INPUTS(2)) dut2 (
        .clk(clk), .reset(rst2), .ireqs(req2), .iresps(resp2),
        .oreq(oreq2), .oresp(oresp2), .busy(busy2), .grant_idx(gnt2)
    );

    cbus_arbiter #(.NUM_INPUTS(4)) dut4 (
        .clk(clk), .reset(rst4), .ireqs(req4), .iresps(resp4),
        .oreq(oreq4), .oresp(oresp4), .busy(busy4), .grant_idx(gnt4)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic cbus_req_t mkreq(input int i, input logic v);
        cbus_req_t r;
        r.valid    = v;
        r.is_write = 1'(i % 2);
        r.size     = 3'd2;
        r.addr     = 32'(32'h1000 * (i + 1));
        r.strobe   = 4'hF;
        r.data     = 32'hA5A5_0000 + 32'(i);
        r.len      = 8'd3;
        r.burst    = 2'd1;
        return r;
    endfunction

    typedef struct {
        logic       rst;
        logic [1:0] v;
        logic       rdy;
        logic       lst;
        logic       eb;
        logic       eg;
        logic       er0;
        logic       er1;
        logic       eov;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [1:0] v, input logic rdy, input logic lst,
                       input logic eb, input logic eg, input logic er0, input logic er1, input logic eov);
        vec_t t;
        t.rst = rst; t.v = v; t.rdy = rdy; t.lst = lst;
        t.eb = eb; t.eg = eg; t.er0 = er0; t.er1 = er1; t.eov = eov;
        tbl.push_back(t);
    endtask

    task automatic drive2(input logic [1:0] v, input logic rdy, input logic lst);
        req2[0]      = mkreq(0, v[0]);
        req2[1]      = mkreq(1, v[1]);
        oresp2.ready = rdy;
        oresp2.last  = lst;
        oresp2.data  = 32'hD00D_0000 + 32'(n_chk);
    endtask

    // Reference model state for the 4-input instance.
    int         m_owner;
    int         m_beats;
    int         m_next;
    logic       e_busy;
    logic [1:0] e_gnt;
    cbus_req_t  e_oreq;
    cbus_resp_t e_resp;

    initial begin
        vec_t t;
        int   grants[$];
        int   last_srv[4];
        int   cyc;

        rst2 = 1'b1; rst4 = 1'b1;
        drive2(2'b11, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) req4[i] = mkreq(i, 1'b1);
        oresp4 = '{ready: 1'b1, last: 1'b0, data: 32'h1234_5678};
        repeat (3) @(negedge clk);

        // First cycle after reset edges: everything idle.
        rst2 = 1'b0; rst4 = 1'b0;
        drive2(2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) req4[i] = mkreq(i, 1'b0);
        #1;
        chk("rst_busy2", busy2, 1'b0);
        chk("rst_gnt2", gnt2, 1'b0);
        chk("rst_oreq2", oreq2, '0);
        chk("rst_resp2", {resp2[0], resp2[1]}, '0);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_gnt4", gnt4, 2'd0);

        // rst, v(bit0=req0), rdy, lst | busy, gnt, iresps[0].ready, iresps[1].ready, oreq.valid
        add(0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b10, 1, 0, 1, 1, 0, 1, 1);
        add(0, 2'b10, 1, 0, 1, 1, 0, 1, 1);
        add(0, 2'b10, 1, 0, 1, 1, 0, 1, 1);
        add(0, 2'b10, 1, 1, 1, 1, 0, 1, 1);
        add(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b11, 1, 1, 0, 0, 0, 0, 0);
        add(0, 2'b11, 1, 1, 1, 0, 1, 0, 1);
        add(0, 2'b11, 1, 1, 0, 0, 0, 0, 0);
        add(0, 2'b11, 1, 1, 1, 1, 0, 1, 1);
        add(0, 2'b11, 1, 1, 0, 0, 0, 0, 0);
        add(0, 2'b11, 1, 1, 1, 0, 1, 0, 1);
        add(0, 2'b11, 1, 1, 0, 0, 0, 0, 0);
        add(0, 2'b11, 1, 1, 1, 1, 0, 1, 1);
        add(0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        add(0, 2'b01, 1, 1, 1, 0, 1, 0, 1);
        add(0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b00, 0, 0, 1, 1, 0, 0, 0);
        add(0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b11, 1, 1, 1, 1, 0, 1, 1);
        add(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b01, 1, 0, 1, 0, 1, 0, 1);
        add(0, 2'b01, 1, 0, 1, 0, 1, 0, 1);
        add(0, 2'b00, 0, 0, 1, 0, 0, 0, 0);
        add(0, 2'b00, 1, 0, 1, 0, 1, 0, 0);
        add(0, 2'b00, 1, 1, 1, 0, 1, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b10, 1, 0, 1, 1, 0, 1, 1);
        add(1, 2'b11, 1, 0, 1, 1, 0, 1, 1);
        add(0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b11, 1, 1, 1, 0, 1, 0, 1);
        add(0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        add(1, 2'b11, 1, 1, 1, 0, 1, 0, 1);
        add(0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        add(0, 2'b11, 0, 0, 1, 0, 0, 0, 1);
        add(1, 2'b00, 0, 0, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            t    = tbl[i];
            rst2 = t.rst;
            drive2(t.v, t.rdy, t.lst);
            #1;
            chk($sformatf("tbl%0d_busy", i), busy2, t.eb);
            chk($sformatf("tbl%0d_gnt", i), gnt2, t.eg);
            chk($sformatf("tbl%0d_rdy", i), {resp2[0].ready, resp2[1].ready}, {t.er0, t.er1});
            chk($sformatf("tbl%0d_ovld", i), oreq2.valid, t.eov);
        end

        // Long burst with valid dropped after beat 1: beat count must saturate, never wrap into an abort.
        @(negedge clk);
        rst2 = 1'b0;
        drive2(2'b01, 1'b0, 1'b0);
        @(negedge clk);
        drive2(2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive2(2'b00, 1'b1, 1'b0);
        end
        @(negedge clk);
        drive2(2'b00, 1'b0, 1'b0);
        #1;
        chk("sat_busy", busy2, 1'b1);
        @(negedge clk);
        drive2(2'b00, 1'b1, 1'b1);
        #1;
        chk("sat_last_rdy", resp2[0].ready, 1'b1);
        @(negedge clk);
        drive2(2'b00, 1'b0, 1'b0);
        #1;
        chk("sat_done", busy2, 1'b0);

        // Fairness on 4 inputs: all valid, single-beat transfers.
        for (int i = 0; i < 4; i++) begin
            req4[i]     = mkreq(i, 1'b1);
            last_srv[i] = -1;
        end
        oresp4 = '{ready: 1'b1, last: 1'b1, data: 32'hFEED_0000};
        cyc = 0;
        while (grants.size() < 12 && cyc < 200) begin
            @(negedge clk);
            #1;
            if (busy4) grants.push_back(int'(gnt4));
            cyc++;
        end
        chk("fair_count", 32'(grants.size()), 32'd12);
        foreach (grants[p]) begin
            chk($sformatf("fair_seq%0d", p), 32'(grants[p]), 32'(p % 4));
            chk($sformatf("fair_wait%0d", p), 32'(p - last_srv[grants[p] % 4] - 1 <= 3), 32'd1);
            last_srv[grants[p] % 4] = p;
        end

        // Randomized run against the behavioural model.
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        m_owner = -1; m_beats = 0; m_next = 0;
        for (int c = 0; c < 2000; c++) begin
            rst4 = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < 4; i++) begin
                req4[i].valid    = ($urandom_range(0, 9) < 6);
                req4[i].is_write = 1'($urandom_range(0, 1));
                req4[i].size     = 3'($urandom_range(0, 7));
                req4[i].addr     = $urandom;
                req4[i].strobe   = 4'($urandom_range(0, 15));
                req4[i].data     = $urandom;
                req4[i].len      = 8'($urandom_range(0, 255));
                req4[i].burst    = 2'($urandom_range(0, 3));
            end
            oresp4.ready = 1'($urandom_range(0, 1));
            oresp4.last  = ($urandom_range(0, 2) == 0);
            oresp4.data  = $urandom;
            #1;
            e_busy = (m_owner >= 0);
            e_gnt  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
            e_oreq = (m_owner >= 0) ? req4[m_owner] : '0;
            chk($sformatf("rnd%0d_busy_gnt", c), {busy4, gnt4}, {e_busy, e_gnt});
            chk($sformatf("rnd%0d_oreq", c), oreq4, e_oreq);
            for (int j = 0; j < 4; j++) begin
                e_resp = (j == m_owner) ? oresp4 : '0;
                chk($sformatf("rnd%0d_resp%0d", c, j), resp4[j], e_resp);
            end

            if (rst4) begin
                m_owner = -1; m_beats = 0; m_next = 0;
            end else if (m_owner < 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (m_owner < 0 && req4[(m_next + k) % 4].valid) begin
                        m_owner = (m_next + k) % 4;
                        m_beats = 0;
                    end
                end
            end else if (oresp4.ready && oresp4.last) begin
                m_next  = (m_owner + 1) % 4;
                m_owner = -1;
                m_beats = 0;
            end else if (m_beats == 0 && !req4[m_owner].valid) begin
                m_owner = -1;
            end else if (oresp4.ready) begin
                m_beats = (m_beats < 255) ? m_beats + 1 : 255;
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
